// File: rtl/lift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lift_pkg
// Description : Shared FSM state and travel-direction encodings for lift_ctrl_n.
// Revision    : 1.0 - initial release
// ============================================================================
package lift_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage
`default_nettype wire

// File: rtl/lift_req_bank.sv
`default_nettype none
// ============================================================================
// Module      : lift_req_bank
// Description : One pending-call register bank with set, per-floor clear,
//               masked end floors and ahead/behind reduction vs the car.
// Revision    : 1.0 - initial release
// ============================================================================
module lift_req_bank
    import lift_pkg::*;
#(
    parameter int FLOORS  = 4,
    parameter int FLOOR_W = 2,
    parameter bit MASK_LO = 1'b0,
    parameter bit MASK_HI = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOORS-1:0]  req,
    input  logic [FLOORS-1:0]  clr,
    input  logic [FLOORS-1:0]  blk,
    input  logic [FLOOR_W-1:0] floor,
    input  logic               dir,
    output logic [FLOORS-1:0]  pend,
    output logic               ahead,
    output logic               behind
);

    logic [FLOORS-1:0] r_pend;
    logic [FLOORS-1:0] w_live;
    logic [FLOORS-1:0] w_above;
    logic [FLOORS-1:0] w_below;

    for (genvar i = 0; i < FLOORS; i++) begin : g_bit
        assign w_live[i]  = !((i == 0 && MASK_LO) || (i == FLOORS - 1 && MASK_HI));
        assign w_above[i] = r_pend[i] && (i > int'(floor));
        assign w_below[i] = r_pend[i] && (i < int'(floor));
    end

    // Clear has priority over a same-cycle request: the call counts as served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend | (req & ~blk)) & ~clr & w_live;
        end
    end

    assign pend   = r_pend;
    assign ahead  = (dir == DIR_UP) ? |w_above : |w_below;
    assign behind = (dir == DIR_UP) ? |w_below : |w_above;

endmodule
`default_nettype wire

// File: rtl/lift_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module      : lift_ctrl_n
// Description : N-floor SCAN elevator controller with timed travel and door.
// Revision    : 1.0 - initial release
// ============================================================================
module lift_ctrl_n
    import lift_pkg::*;
#(
    parameter int FLOORS        = 4,
    parameter int FLOOR_W       = $clog2(FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOORS-1:0]  up_req,
    input  logic [FLOORS-1:0]  dn_req,
    input  logic [FLOORS-1:0]  car_req,
    output logic [FLOOR_W-1:0] floor,
    output logic               dir,
    output logic               moving,
    output logic               door_open,
    output logic [FLOORS-1:0]  up_pend,
    output logic [FLOORS-1:0]  dn_pend,
    output logic [FLOORS-1:0]  car_pend
);

    localparam int c_tcnt_w = $clog2(TRAVEL_CYCLES + 1);
    localparam int c_dcnt_w = $clog2(DOOR_CYCLES + 1);
    localparam logic [c_tcnt_w-1:0] c_tcnt_last = c_tcnt_w'(TRAVEL_CYCLES - 1);
    localparam logic [c_dcnt_w-1:0] c_dcnt_last = c_dcnt_w'(DOOR_CYCLES - 1);
    localparam logic [FLOORS-1:0]   c_up_mask   = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0]   c_dn_mask   = {{(FLOORS-1){1'b1}}, 1'b0};

    state_t              r_state;
    logic [FLOOR_W-1:0]  r_floor;
    logic                r_dir;
    logic                r_moving;
    logic                r_door_open;
    logic                r_arrived;
    logic [c_tcnt_w-1:0] r_tcnt;
    logic [c_dcnt_w-1:0] r_dcnt;

    logic [FLOORS-1:0] w_here_1h;
    logic [FLOORS-1:0] w_clr_car, w_clr_up, w_clr_dn;
    logic [FLOORS-1:0] w_blk_car, w_blk_up, w_blk_dn;
    logic w_car_ahead, w_up_ahead, w_dn_ahead;
    logic w_car_behind, w_up_behind, w_dn_behind;
    logic w_ahead, w_behind, w_above, w_below;
    logic w_car_here, w_up_here, w_dn_here;
    logic w_hall_dir_here, w_hall_opp_here, w_here, w_any_here;
    logic w_in_door, w_door_req, w_door_last;
    logic w_enter_door, w_entry_dir, w_door_flip;

    assign w_here_1h = {{(FLOORS-1){1'b0}}, 1'b1} << r_floor;

    lift_req_bank #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W), .MASK_LO(1'b0), .MASK_HI(1'b1)) u_up (
        .clk(clk), .rst(rst), .req(up_req), .clr(w_clr_up), .blk(w_blk_up),
        .floor(r_floor), .dir(r_dir), .pend(up_pend), .ahead(w_up_ahead), .behind(w_up_behind)
    );

    lift_req_bank #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W), .MASK_LO(1'b1), .MASK_HI(1'b0)) u_dn (
        .clk(clk), .rst(rst), .req(dn_req), .clr(w_clr_dn), .blk(w_blk_dn),
        .floor(r_floor), .dir(r_dir), .pend(dn_pend), .ahead(w_dn_ahead), .behind(w_dn_behind)
    );

    lift_req_bank #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W), .MASK_LO(1'b0), .MASK_HI(1'b0)) u_car (
        .clk(clk), .rst(rst), .req(car_req), .clr(w_clr_car), .blk(w_blk_car),
        .floor(r_floor), .dir(r_dir), .pend(car_pend), .ahead(w_car_ahead), .behind(w_car_behind)
    );

    assign w_ahead         = w_car_ahead | w_up_ahead | w_dn_ahead;
    assign w_behind        = w_car_behind | w_up_behind | w_dn_behind;
    assign w_above         = (r_dir == DIR_UP) ? w_ahead : w_behind;
    assign w_below         = (r_dir == DIR_UP) ? w_behind : w_ahead;
    assign w_car_here      = |(car_pend & w_here_1h);
    assign w_up_here       = |(up_pend & w_here_1h);
    assign w_dn_here       = |(dn_pend & w_here_1h);
    assign w_hall_dir_here = (r_dir == DIR_UP) ? w_up_here : w_dn_here;
    assign w_hall_opp_here = (r_dir == DIR_UP) ? w_dn_here : w_up_here;
    assign w_here          = w_car_here | w_hall_dir_here;
    assign w_any_here      = w_car_here | w_up_here | w_dn_here;

    // While the door is open, calls for this floor in the travel direction hold it open instead of latching.
    assign w_in_door   = (r_state == DOOR);
    assign w_door_last = (r_dcnt == c_dcnt_last);
    assign w_door_req  = |(car_req & w_here_1h) |
                         ((r_dir == DIR_UP) ? |(up_req & c_up_mask & w_here_1h)
                                            : |(dn_req & c_dn_mask & w_here_1h));
    assign w_blk_car   = w_in_door ? w_here_1h : '0;
    assign w_blk_up    = (w_in_door && r_dir == DIR_UP) ? w_here_1h : '0;
    assign w_blk_dn    = (w_in_door && r_dir == DIR_DN) ? w_here_1h : '0;

    always_comb begin
        w_enter_door = 1'b0;
        w_entry_dir  = r_dir;
        w_door_flip  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_here) begin
                    w_enter_door = 1'b1;
                    if (!w_hall_dir_here && w_hall_opp_here) begin
                        w_entry_dir = ~r_dir;
                    end
                end
            end
            MOVE: w_enter_door = r_arrived && (w_here || (!w_ahead && w_any_here));
            DOOR: w_door_flip  = !w_door_req && w_door_last && !w_ahead && w_hall_opp_here;
            default: ;
        endcase
    end

    // Entering DOOR serves the car call and the hall call matching the (new) direction.
    assign w_clr_car = w_enter_door ? w_here_1h : '0;
    assign w_clr_up  = ((w_enter_door && w_entry_dir == DIR_UP) || (w_door_flip && r_dir == DIR_DN))
                       ? w_here_1h : '0;
    assign w_clr_dn  = ((w_enter_door && w_entry_dir == DIR_DN) || (w_door_flip && r_dir == DIR_UP))
                       ? w_here_1h : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_floor     <= '0;
            r_dir       <= DIR_UP;
            r_moving    <= 1'b0;
            r_door_open <= 1'b0;
            r_arrived   <= 1'b0;
            r_tcnt      <= '0;
            r_dcnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_enter_door) begin
                        r_state     <= DOOR;
                        r_dir       <= w_entry_dir;
                        r_door_open <= 1'b1;
                        r_dcnt      <= '0;
                    end else if (w_above || w_below) begin
                        r_state   <= MOVE;
                        r_dir     <= w_above ? DIR_UP : DIR_DN;
                        r_moving  <= 1'b1;
                        r_tcnt    <= '0;
                        r_arrived <= 1'b0;
                    end
                end
                MOVE: begin
                    if (!r_arrived) begin
                        if (r_tcnt == c_tcnt_last) begin
                            r_floor   <= (r_dir == DIR_DN) ? r_floor - FLOOR_W'(1) : r_floor + FLOOR_W'(1);
                            r_arrived <= 1'b1;
                            r_tcnt    <= '0;
                        end else begin
                            r_tcnt <= r_tcnt + c_tcnt_w'(1);
                        end
                    end else if (w_enter_door) begin
                        r_state     <= DOOR;
                        r_moving    <= 1'b0;
                        r_door_open <= 1'b1;
                        r_dcnt      <= '0;
                    end else if (w_ahead) begin
                        r_arrived <= 1'b0;
                    end else begin
                        r_state  <= IDLE;
                        r_moving <= 1'b0;
                    end
                end
                DOOR: begin
                    if (w_door_req) begin
                        r_dcnt <= '0;
                    end else if (!w_door_last) begin
                        r_dcnt <= r_dcnt + c_dcnt_w'(1);
                    end else if (w_ahead) begin
                        r_state     <= MOVE;
                        r_door_open <= 1'b0;
                        r_moving    <= 1'b1;
                        r_tcnt      <= '0;
                        r_arrived   <= 1'b0;
                    end else if (w_door_flip) begin
                        r_dir  <= ~r_dir;
                        r_dcnt <= '0;
                    end else if (w_behind) begin
                        r_state     <= MOVE;
                        r_dir       <= ~r_dir;
                        r_door_open <= 1'b0;
                        r_moving    <= 1'b1;
                        r_tcnt      <= '0;
                        r_arrived   <= 1'b0;
                    end else begin
                        r_state     <= IDLE;
                        r_door_open <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign floor     = r_floor;
    assign dir       = r_dir;
    assign moving    = r_moving;
    assign door_open = r_door_open;

endmodule
`default_nettype wire

// File: tb/tb_lift_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_lift_ctrl_n
// Description : Self-checking bench for lift_ctrl_n against a countdown model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lift_ctrl_n;

    localparam int F  = 4;
    localparam int FW = 2;
    localparam int TC = 4;
    localparam int DC = 3;

    localparam int M_IDLE   = 0;
    localparam int M_TRAVEL = 1;
    localparam int M_DECIDE = 2;
    localparam int M_DOOR   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [F-1:0]  up_req = '0;
    logic [F-1:0]  dn_req = '0;
    logic [F-1:0]  car_req = '0;
    logic [FW-1:0] floor;
    logic          dir, moving, door_open;
    logic [F-1:0]  up_pend, dn_pend, car_pend;

    int n_vec = 0;
    int n_err = 0;

    int           m_floor, m_mode, m_left;
    bit           m_dir;
    logic [F-1:0] m_up, m_dn, m_car;

    lift_ctrl_n #(
        .FLOORS(F), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
    ) dut (
        .clk(clk), .rst(rst), .up_req(up_req), .dn_req(dn_req), .car_req(car_req),
        .floor(floor), .dir(dir), .moving(moving), .door_open(door_open),
        .up_pend(up_pend), .dn_pend(dn_pend), .car_pend(car_pend)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status();
        return 32'({floor, dir, moving, door_open, up_pend, dn_pend, car_pend});
    endfunction

    function automatic logic [31:0] model_status();
        logic mv, dr;
        mv = (m_mode == M_TRAVEL || m_mode == M_DECIDE);
        dr = (m_mode == M_DOOR);
        return 32'({FW'(m_floor), m_dir, mv, dr, m_up, m_dn, m_car});
    endfunction

    function automatic bit m_call_at(int f);
        return m_up[f] | m_dn[f] | m_car[f];
    endfunction

    function automatic bit m_hall(bit d, int f);
        return d ? m_dn[f] : m_up[f];
    endfunction

    // Any pending call strictly past the car in direction d (0 = up).
    function automatic bit m_beyond(bit d);
        for (int f = 0; f < F; f++) begin
            if (m_call_at(f) && (d ? (f < m_floor) : (f > m_floor))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_dir = 1'b0; m_mode = M_IDLE; m_left = 0;
        m_up = '0; m_dn = '0; m_car = '0;
    endtask

    task automatic model_step(input logic [F-1:0] ui, input logic [F-1:0] di, input logic [F-1:0] ci);
        logic [F-1:0] u, d, nu, nd, nc;
        bit here, ahead, behind, door_req, open;
        int f;
        u = ui; d = di;
        u[F-1] = 1'b0;
        d[0]   = 1'b0;
        f      = m_floor;
        here   = m_car[f] | m_hall(m_dir, f);
        ahead  = m_beyond(m_dir);
        behind = m_beyond(!m_dir);
        door_req = ci[f] | (m_dir ? d[f] : u[f]);
        nu = m_up | u; nd = m_dn | d; nc = m_car | ci;
        if (m_mode == M_DOOR) begin
            nc[f] = m_car[f];
            if (m_dir) nd[f] = m_dn[f]; else nu[f] = m_up[f];
        end
        open = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (m_call_at(f)) begin
                    if (!m_hall(m_dir, f) && m_hall(!m_dir, f)) m_dir = !m_dir;
                    open = 1'b1;
                end else if (m_beyond(1'b0)) begin
                    m_dir = 1'b0; m_mode = M_TRAVEL; m_left = TC;
                end else if (m_beyond(1'b1)) begin
                    m_dir = 1'b1; m_mode = M_TRAVEL; m_left = TC;
                end
            end
            M_TRAVEL: begin
                m_left--;
                if (m_left == 0) begin
                    m_floor = m_floor + (m_dir ? -1 : 1);
                    m_mode  = M_DECIDE;
                end
            end
            M_DECIDE: begin
                if (here || (!ahead && m_call_at(f))) open = 1'b1;
                else if (ahead) begin m_mode = M_TRAVEL; m_left = TC; end
                else m_mode = M_IDLE;
            end
            default: begin
                if (door_req) m_left = DC;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (ahead) begin
                            m_mode = M_TRAVEL; m_left = TC;
                        end else if (m_hall(!m_dir, f)) begin
                            if (m_dir) nu[f] = 1'b0; else nd[f] = 1'b0;
                            m_dir = !m_dir; m_left = DC;
                        end else if (behind) begin
                            m_dir = !m_dir; m_mode = M_TRAVEL; m_left = TC;
                        end else m_mode = M_IDLE;
                    end
                end
            end
        endcase
        if (open) begin
            m_mode = M_DOOR; m_left = DC;
            nc[f] = 1'b0;
            if (m_dir) nd[f] = 1'b0; else nu[f] = 1'b0;
        end
        m_up = nu; m_dn = nd; m_car = nc;
    endtask

    // Starts and ends at a falling edge; inputs are held across the rising edge.
    task automatic cycle(input logic [F-1:0] u, input logic [F-1:0] d, input logic [F-1:0] c);
        up_req = u; dn_req = d; car_req = c;
        @(posedge clk);
        #1;
        model_step(u, d, c);
        @(negedge clk);
        up_req = '0; dn_req = '0; car_req = '0;
        check("state", status(), model_status());
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", status(), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_until_idle(input int max);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            if (!moving && !door_open && up_pend == '0 && dn_pend == '0 && car_pend == '0) done = 1'b1;
            else cycle('0, '0, '0);
        end
        check("idle_reached", 32'({moving, door_open}), 32'd0);
    endtask

    initial begin
        int           stops[$];
        int           exp3[3];
        int           n, sel, b;
        bit           prev, found;
        logic [F-1:0] u, d, c;
        exp3 = '{4, 6, 3};
        model_reset();

        #3;
        check("reset_vals", status(), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 1; k <= 16; k++) begin
            cycle('0, '0, (k == 1) ? 4'b0100 : 4'b0000);
            if (k == 1)  check("t2_pend_set", 32'({car_pend, moving}), 32'b01000);
            if (k == 2)  check("t2_move", 32'(moving), 32'd1);
            if (k == 5)  check("t2_floor0", 32'(floor), 32'd0);
            if (k == 6)  check("t2_floor1", 32'(floor), 32'd1);
            if (k == 10) check("t2_floor1b", 32'(floor), 32'd1);
            if (k == 11) check("t2_floor2", 32'(floor), 32'd2);
            if (k == 12) check("t2_door_entry", 32'({door_open, car_pend}), 32'b10000);
            if (k == 14) check("t2_door_last", 32'(door_open), 32'd1);
            if (k == 15) check("t2_idle", 32'({door_open, moving, floor}), 32'd2);
        end

        cycle('0, '0, 4'b0001);
        run_until_idle(60);
        check("home_floor", 32'(floor), 32'd0);

        prev = 1'b0;
        for (int k = 0; k < 120; k++) begin
            cycle((k == 3) ? 4'b0100 : 4'b0000, (k == 3) ? 4'b0010 : 4'b0000,
                  (k == 0) ? 4'b1000 : 4'b0000);
            if (door_open && !prev) stops.push_back(int'({floor, dir}));
            prev = door_open;
            if (k > 3 && !moving && !door_open) break;
        end
        check("t3_nstops", 32'(stops.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check("t3_stop", 32'((i < stops.size()) ? stops[i] : 99), 32'(exp3[i]));
        check("t3_final", 32'({floor, dir, moving}), 32'b0110);

        found = 1'b0;
        cycle('0, '0, 4'b0100);
        for (int k = 0; k < 40 && !found; k++) begin
            if (door_open) found = 1'b1;
            else cycle('0, '0, '0);
        end
        check("t4_door_at2", 32'({found, floor, dir}), 32'b1100);
        cycle('0, '0, '0);
        cycle(4'b0100, '0, 4'b0100);
        n = 2;
        for (int k = 0; k < 20 && door_open; k++) begin
            n++;
            cycle('0, '0, '0);
        end
        check("t4_door_len", 32'(n), 32'd5);
        check("t4_no_latch", 32'({up_pend, car_pend}), 32'd0);

        cycle(4'b1000, 4'b0001, '0);
        check("t5_mask_now", 32'({up_pend, dn_pend, car_pend, moving, door_open}), 32'd0);
        for (int k = 0; k < 5; k++) cycle('0, '0, '0);
        check("t5_mask_later", 32'({up_pend, dn_pend, car_pend, moving, door_open}), 32'd0);

        found = 1'b0;
        cycle('0, '0, 4'b0001);
        for (int k = 0; k < 40 && !found; k++) begin
            if (moving && floor == 2'd1) found = 1'b1;
            else cycle('0, '0, '0);
        end
        check("t6_found", 32'({found, car_pend}), 32'b10001);
        async_reset();
        for (int k = 0; k < 8; k++) cycle('0, '0, '0);
        check("t6_quiet", 32'({floor, moving, door_open}), 32'd0);

        for (int k = 0; k < 2500; k++) begin
            u = '0; d = '0; c = '0;
            if ($urandom_range(0, 5) == 0) begin
                sel = int'($urandom_range(0, 2));
                b   = int'($urandom_range(0, F - 1));
                if (sel == 0) u[b] = 1'b1;
                else if (sel == 1) d[b] = 1'b1;
                else c[b] = 1'b1;
            end
            if ($urandom_range(0, 799) == 0) async_reset();
            else cycle(u, d, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lift_ctrl_n.md
# lift_ctrl_n

Parametrised elevator controller for an N-floor car, the successor to the fixed 4-floor lift FSM. It latches hall calls (up/down) and car calls into pending registers and serves them in SCAN order: continue in the current direction while demand remains ahead, then reverse. Floor travel and door dwell are timed by counters, so position advances at a realistic rate. It sits between the call-button decoders and the motor/door drivers.

## Interface
- FLOORS, 4: number of floors, ≥2; floors are numbered 0..FLOORS-1.
- FLOOR_W, $clog2(FLOORS): floor index width.
- TRAVEL_CYCLES, 4: cycles to move one floor, ≥1.
- DOOR_CYCLES, 3: cycles the door stays open, ≥1.
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- up_req  in  FLOORS  hall-up call pulses; bit FLOORS-1 is ignored.
- dn_req  in  FLOORS  hall-down call pulses; bit 0 is ignored.
- car_req  in  FLOORS  in-car call pulses.
- floor  out  FLOOR_W  current car floor.
- dir  out  1  0 = up, 1 = down.
- moving  out  1  1 in MOVE.
- door_open  out  1  1 in DOOR.
- up_pend, dn_pend, car_pend  out  FLOORS each  pending-call registers.

## Operation
- Reset values:
  - floor=0, dir=0, moving=0, door_open=0.
  - All pend=0, both counters 0, state IDLE.
- Pending bits:
  - Each bit is OR-ed with its request every cycle and is registered.
  - A bit clears only when its call is served (see DOOR).
- Terms:
  - "ahead" = any pending bit strictly beyond floor in dir.
  - "behind" = the same in the opposite direction.
  - "here" = car_pend[floor], or the hall bit at floor matching dir.
- States IDLE / MOVE / DOOR.
- IDLE: priority is first match wins.
  - Here, or either hall bit at floor → DOOR; set dir toward the hall bit if only the opposite one is set.
  - Else pending above → dir=0, MOVE.
  - Else pending below → dir=1, MOVE.
  - Else stay.
- MOVE:
  - The counter runs from 0 to TRAVEL_CYCLES-1.
  - On its last cycle, floor±1 is applied at the edge.
  - The stop decision is evaluated at the new floor on the following cycle.
  - Stop (→ DOOR) if here is true, or if nothing is ahead and any call is at this floor.
  - Otherwise stay in MOVE with the counter restarted.
  - Floor never passes 0 or FLOORS-1; SCAN direction guarantees this.
- DOOR:
  - On entry, clear car_pend[floor] and the hall bit for dir at floor.
  - Any request for floor in this state (car, or hall in dir) is not latched and restarts the door counter.
  - When the counter expires, take the first match:
    - Ahead → MOVE, same dir.
    - Opposite hall bit at floor → flip dir, clear that bit, restart DOOR.
    - Behind → flip dir, MOVE.
    - Else → IDLE.
- Simultaneous set and clear of the same pend bit on the entry edge: clear wins; the request is treated as already served.

## Timing
- A request pulse in cycle t appears in pend at t+1.
- IDLE leaves on the edge ending cycle t+1.
- From MOVE entry, floor changes after exactly TRAVEL_CYCLES cycles.
- Each further floor takes TRAVEL_CYCLES+1 cycles: the stop-decision cycle plus the travel cycles.
- door_open is high for DOOR_CYCLES cycles, or longer if restarted.
- All outputs are registered; there is no combinational path from input to output.
- rst mid-operation: all state returns to reset values immediately and asynchronously; in-flight calls are lost.

## Structure
- Package lift_pkg:
  - State enum {IDLE, MOVE, DOOR}.
  - DIR_UP=0, DIR_DN=1.
- Sub-module lift_req_bank (per-direction pending register with set, per-floor clear and masked ends).
  - Instantiated for up_req, dn_req and car_req.
  - Also provides the ahead/behind reduction against floor and dir.
- Top level holds the FSM, the travel/door counters and the floor register.

## Test plan
Parameters FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=3.
1. Reset:
   - Assert rst asynchronously mid-cycle.
   - Required: floor=0, dir=0, door_open=0, moving=0, all pend=0 immediately.
2. Single call:
   - Pulse car_req[2] at floor 0.
   - Required: MOVE 2 cycles after the pulse; floor=1 after 4 cycles and floor=2 after 9 (timed from MOVE entry).
   - Required: door_open for 3 cycles, car_pend[2] cleared on DOOR entry, then IDLE with floor=2.
3. SCAN order:
   - At floor 0, pulse car_req[3]; while moving to floor 1, pulse dn_req[1] and up_req[2].
   - Required: the car passes floor 1, stops at 2 then 3, reverses (dir=1), stops at 1, then goes IDLE.
4. Door hold:
   - During DOOR at floor 2 (dir=0), pulse car_req[2] and up_req[2] on door cycle 2.
   - Required: the counter restarts (door_open lasts 5 cycles total) and neither pend bit sets.
5. End masking:
   - Pulse up_req[3] and dn_req[0].
   - Required: pend stays 0 and the car stays IDLE.
6. Reset mid-MOVE:
   - Assert rst while floor=1 and moving.
   - Required: floor=0, moving=0, pend cleared; after release, no motion without new requests.
